// File: rtl/ps2_scan_rx.sv
// ---------------------------------------------------------------------------
// ps2_scan_rx
// PS/2 keyboard receive front end. Conditions the raw PS/2 clock/data pins
// (2-FF synchronisers plus a run-length glitch filter on the clock), then
// deserialises the 11-bit frame {start, d0..d7, parity, stop} into an 8-bit
// scan code with a parity-good flag for the scan-code-to-glyph stage.
//
// Optional feature: define PS2_BREAK_FILTER_EN to swallow E0 prefixes and
// F0-prefixed break sequences so only make codes are emitted.
//
// Parameters
//   FILTER_LEN      consecutive equal samples before the filtered clock moves
//   TIMEOUT_CYCLES  clocks without a filtered falling edge mid-frame -> abort
//
// Ports
//   clk         in   system clock, posedge
//   rst_n       in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   scan_code   out  [7:0] last received code, held between frames
//   par         out  1 = odd parity of the last emitted frame was correct
//   code_valid  out  one-cycle pulse when scan_code/par update
//   frame_err   out  one-cycle pulse on bad stop bit or timeout
// ---------------------------------------------------------------------------
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       par,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          r_clk_s1, r_clk_s2;
  logic          r_dat_s1, r_dat_s2;
  logic          r_fclk, r_fclk_d;
  logic [FW-1:0] r_fcnt;
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_bit;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_scan_code;
  logic          r_par;
  logic          r_code_valid;
  logic          r_frame_err;
`ifdef PS2_BREAK_FILTER_EN
  logic          r_break_pending;
`endif

  logic w_fall;
  logic w_timeout;

  // Synchronisers idle high, matching the PS/2 bus idle level, so reset
  // release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock follows the synchronised clock only after FILTER_LEN
  // consecutive samples that disagree with it; any agreeing sample restarts
  // the run, so short glitches are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fclk   <= 1'b1;
      r_fclk_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_fclk_d <= r_fclk;
      if (r_clk_s2 == r_fclk) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_fclk <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  // The one-cycle strobe is taken from the registered copy so the frame
  // engine acts one clock after the filtered clock moves.
  assign w_fall    = r_fclk_d & ~r_fclk;
  assign w_timeout = (r_state != S_IDLE) && (r_tcnt == TW'(TIMEOUT_CYCLES));

  // Mid-frame inactivity counter; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (r_state == S_IDLE || w_fall) begin
      r_tcnt <= '0;
    end else if (r_tcnt != TW'(TIMEOUT_CYCLES)) begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // Frame engine. Pulses default low every cycle; every pulse returns the
  // FSM to IDLE, and IDLE produces no pulse, so pulses can never repeat on
  // consecutive cycles or coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_par_bit       <= 1'b0;
      r_scan_code     <= 8'h00;
      r_par           <= 1'b0;
      r_code_valid    <= 1'b0;
      r_frame_err     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      r_break_pending <= 1'b0;
`endif
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            // A high start bit is treated as line noise, not an error.
            if (!r_dat_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          S_PARITY: begin
            r_par_bit <= r_dat_s2;
            r_state   <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (r_dat_s2) begin
`ifdef PS2_BREAK_FILTER_EN
              // E0 is dropped outright; F0 arms the swallow of the
              // following code, so only make codes go downstream.
              if (r_shift == 8'hF0) begin
                r_break_pending <= 1'b1;
              end else if (r_shift != 8'hE0) begin
                if (r_break_pending) begin
                  r_break_pending <= 1'b0;
                end else begin
                  r_scan_code  <= r_shift;
                  r_par        <= ^{r_shift, r_par_bit};
                  r_code_valid <= 1'b1;
                end
              end
`else
              r_scan_code  <= r_shift;
              r_par        <= ^{r_shift, r_par_bit};
              r_code_valid <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              r_break_pending <= 1'b0;
`endif
            end
          end
        endcase
      end else if (w_timeout) begin
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
        r_break_pending <= 1'b0;
`endif
      end
    end
  end

  assign scan_code  = r_scan_code;
  assign par        = r_par;
  assign code_valid = r_code_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_rx.sv
module tb_ps2_scan_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 600;
  localparam int HALF    = 30;   // PS/2 half bit period in system clocks
  localparam int LAT     = 2 + FILTER + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       par;
  logic       code_valid;
  logic       frame_err;

  ps2_scan_rx #(.FILTER_LEN(FILTER), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .par(par), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_rule = 0;   // overlapping or back-to-back pulses
  int lat;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  // Pulse monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (code_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
    if (code_valid === 1'b1 && frame_err === 1'b1) n_rule++;
    if ((code_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_e)) n_rule++;
    prev_v = (code_valid === 1'b1);
    prev_e = (frame_err === 1'b1);
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives n bits LSB first; on the 11th bit (stop) measures clocks from the
  // raw falling edge to code_valid.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        lat = -1;
        for (int k = 1; k <= HALF; k++) begin
          @(posedge clk);
          #1;
          if (code_valid === 1'b1 && lat < 0) lat = k;
        end
        @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_bits({stop, p, d, 1'b0}, 11);
    repeat (FILTER + 10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scan_code", scan_code, 0);
    check("rst_par", par, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Reference model: what the receiver should report for a whole frame.
  logic [7:0] m_code;
  logic       m_par;
  logic       m_pending;

  task automatic model_frame(input logic [7:0] d, input logic p, input logic stop,
                             output int ev, output int ee);
    ev = 0;
    ee = 0;
    if (!stop) begin
      ee = 1;
      m_pending = 1'b0;
    end else begin
      ev = 1;
`ifdef PS2_BREAK_FILTER_EN
      if (d == 8'hE0) ev = 0;
      else if (d == 8'hF0) begin ev = 0; m_pending = 1'b1; end
      else if (m_pending) begin ev = 0; m_pending = 1'b0; end
`endif
      if (ev == 1) begin
        m_code = d;
        m_par  = (($countones({d, p}) % 2) == 1);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_code;
    logic       exp_par;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, e0, ev, ee;
    logic [7:0] d;
    logic p, s;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b1};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1, 0, 8'h1C, 1'b0};
    vecs[2] = '{8'h32, 1'b0, 1'b0, 0, 1, 8'h1C, 1'b0};
    vecs[3] = '{8'h32, 1'b0, 1'b1, 1, 0, 8'h32, 1'b1};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1, 0, 8'hA5, 1'b1};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 1, 0, 8'hA5, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1, 0, 8'h00, 1'b1};
    vecs[7] = '{8'hFF, 1'b0, 1'b0, 0, 1, 8'h00, 1'b1};

    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("init_scan_code", scan_code, 0);
    check("init_par", par, 0);
    check("init_code_valid", code_valid, 0);
    check("init_frame_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stop);
      $display("vec %0d data=%02h p=%0b stop=%0b -> code=%02h par=%0b", i,
               vecs[i].data, vecs[i].pbit, vecs[i].stop, scan_code, par);
      check("vec_valid_cnt", n_valid - v0, vecs[i].exp_v);
      check("vec_err_cnt", n_err - e0, vecs[i].exp_e);
      check("vec_scan_code", scan_code, vecs[i].exp_code);
      check("vec_par", par, vecs[i].exp_par);
      if (vecs[i].exp_v == 1) check("vec_latency", lat, LAT);
    end

    // Partial frame then silence: one timeout error, then recovery.
    v0 = n_valid; e0 = n_err;
    send_bits(11'b000_0000_1010, 4);
    repeat (TIMEOUT + 40) @(negedge clk);
    $display("timeout: err pulses=%0d", n_err - e0);
    check("timeout_err_cnt", n_err - e0, 1);
    check("timeout_valid_cnt", n_valid - v0, 0);
    v0 = n_valid;
    send_frame(8'h32, 1'b0, 1'b1);
    $display("after timeout: code=%02h par=%0b", scan_code, par);
    check("post_timeout_valid", n_valid - v0, 1);
    check("post_timeout_code", scan_code, 8'h32);
    check("post_timeout_par", par, 1);

    // Short low glitch on ps2_clk with data low must not start a frame.
    v0 = n_valid; e0 = n_err;
    ps2_data = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    ps2_data = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_pulses", (n_valid - v0) + (n_err - e0), 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    $display("after glitch: code=%02h par=%0b", scan_code, par);
    check("post_glitch_valid", n_valid - v0, 1);
    check("post_glitch_err", n_err - e0, 0);
    check("post_glitch_code", scan_code, 8'h1C);

    // Reset in the middle of a frame, then a clean frame.
    send_bits(11'b000_0001_0110, 5);
    v0 = n_valid; e0 = n_err;
    do_reset();
    check("midrst_pulses", (n_valid - v0) + (n_err - e0), 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    $display("after reset: code=%02h par=%0b", scan_code, par);
    check("post_rst_valid", n_valid - v0, 1);
    check("post_rst_code", scan_code, 8'h1C);
    check("post_rst_par", par, 1);

    // Break prefix followed by a code.
    v0 = n_valid;
    send_frame(8'hF0, 1'b1, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
    send_frame(8'h1C, 1'b0, 1'b1);
    $display("break seq: pulses=%0d", n_valid - v0);
    check("break_swallowed", n_valid - v0, 0);
`else
    $display("break seq: code=%02h par=%0b", scan_code, par);
    check("f0_valid", n_valid - v0, 1);
    check("f0_code", scan_code, 8'hF0);
    check("f0_par", par, 1);
    send_frame(8'h1C, 1'b0, 1'b1);
    $display("break seq: code=%02h par=%0b", scan_code, par);
    check("f0_1c_valid", n_valid - v0, 2);
    check("f0_1c_code", scan_code, 8'h1C);
    check("f0_1c_par", par, 1);
`endif

    // Randomised frames against the reference model.
    do_reset();
    m_code = 8'h00; m_par = 1'b0; m_pending = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 4) != 0);
      model_frame(d, p, s, ev, ee);
      v0 = n_valid; e0 = n_err;
      send_frame(d, p, s);
      $display("rand %0d data=%02h p=%0b stop=%0b -> code=%02h par=%0b", i, d, p, s, scan_code, par);
      check("rand_valid_cnt", n_valid - v0, ev);
      check("rand_err_cnt", n_err - e0, ee);
      check("rand_scan_code", scan_code, m_code);
      check("rand_par", par, m_par);
    end

    check("pulse_rules", n_rule, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
PS/2 keyboard receive front end. Deserialises the device-clocked 11-bit PS/2 frame into an 8-bit scan code with parity status. Feeds the scan-code-to-glyph lookup stage directly through its `scan_code` and `par` inputs. Sits between the board PS/2 pins and the character and display path.

Parameters:
- FILTER_LEN, 8: consecutive identical system-clock samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 100000: system clocks without a filtered falling edge, mid-frame, before the frame is aborted (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- scan_code  output  8  last received code; held between frames.
- par  output  1  1 = odd parity of last frame correct.
- code_valid  output  1  one-cycle pulse when scan_code/par are updated.
- frame_err  output  1  one-cycle pulse on a stop-bit error or a timeout.

Behaviour:
- Reset, asynchronous on rst_n low:
  - scan_code=8'h00, par=0, code_valid=0, frame_err=0.
  - FSM to IDLE; bit counter, filter counter and timeout counter cleared.
  - Synchroniser and filtered-clock registers set to 1.
  - A reset mid-frame discards the partial frame with no pulse.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The filtered clock changes only after FILTER_LEN consecutive equal synchronised samples.
  - A filtered falling edge (1 to 0) is the sole sample strobe; ps2_data (synchronised) is sampled on that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 (start bit), go to DATA with bit_cnt=0. On an edge with data=1, stay in IDLE; no error is raised.
  - DATA: shift data in LSB first. bit_cnt increments per edge. After bit_cnt=7 is sampled, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP, data=1: scan_code <= shift reg and par <= ^{shift reg, parity bit}. code_valid pulses exactly one clk after the stop-bit edge strobe. Return to IDLE.
  - STOP, data=0: frame_err pulses. scan_code and par are unchanged and there is no code_valid. Return to IDLE.
- Parity failure is not an error: the code is still emitted with par=0. Downstream decides what to do with it.
- Timeout:
  - Counter cleared on every filtered edge and held at 0 in IDLE.
  - In DATA, PARITY or STOP, reaching TIMEOUT_CYCLES gives a frame_err pulse and returns to IDLE.
  - The counter saturates; it does not wrap.
- code_valid and frame_err are never asserted in the same cycle. Neither is asserted for 2 consecutive cycles.
- End-to-end latency from the raw ps2_clk falling edge of the stop bit to code_valid is 2 + FILTER_LEN + 1 clk.
- Counter widths: $clog2(FILTER_LEN+1) and $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- Defined:
  - A good-stop-bit frame of 8'hE0 is swallowed: no code_valid.
  - A frame of 8'hF0 is swallowed and sets break_pending. The next good frame is also swallowed and clears break_pending.
  - Only make codes reach the glyph stage.
  - break_pending is cleared by reset and by a frame_err.
- Undefined: every good frame, including E0 and F0, is emitted.

Test Plan:
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) at 10 kHz PS/2 clock -> exactly one code_valid, scan_code=8'h1C, par=1, frame_err never high.
- Frame 0x1C with parity bit 1 -> code_valid once, scan_code=8'h1C, par=0.
- Frame 0x32 with stop bit 0, after a prior good 0x1C -> frame_err pulse, no code_valid, scan_code stays 8'h1C.
- Start bit plus 3 data bits, then idle for TIMEOUT_CYCLES+10 clk -> single frame_err. Then a full 0x32 frame (parity 0) -> scan_code=8'h32, par=1.
- 3-clk low glitch on ps2_clk between frames (FILTER_LEN=8) -> no state change, no pulses. Also assert rst_n low mid-frame -> outputs return to reset values, and the next 0x1C frame is received correctly.
- F0 (parity 1) then 1C:
  - With PS2_BREAK_FILTER_EN -> zero code_valid pulses.
  - Without it -> two pulses, scan_code 8'hF0 then 8'h1C, par=1 both.
